cpu_output_uart: RTL and testbench
==================================

// Module: cpu_output_uart
// PURPOSE
//  Downstream consumer of the CPU core's output port. Captures each 32-bit data_out word on output_en,
//  buffers words in a small FIFO, and serializes them as four 8N1 UART bytes, least significant byte first.
//  Sits beside riscv_cpu_main at top level; drives the board tx pin.
// PARAMETERS
//  WORD_SIZE     32   input word width; fixed at 32 (4 bytes/word)
//  FIFO_DEPTH    8    words buffered; power of 2, >=2
//  CLKS_PER_BIT  868  clk cycles per UART bit (100 MHz / 115200); >=2
// PORTS
//  clk         in   1          system clock, rising edge
//  rst         in   1          asynchronous, active-low reset
//  wr_en       in   1          write strobe (core output_en)
//  wr_data     in   WORD_SIZE  word to send (core data_out)
//  full        out  1          FIFO holds FIFO_DEPTH words
//  empty       out  1          FIFO holds 0 words
//  busy        out  1          serializer mid-word (state != IDLE)
//  overflow    out  1          sticky: a write was dropped while full
//  tx          out  1          UART line, idle high
// BEHAVIOUR
//  Reset (rst=0, async): FIFO pointers/count=0, state=IDLE, tx=1, busy=0, full=0, empty=1, overflow=0.
//   Reset mid-frame aborts the byte: tx returns high immediately, buffered words are discarded.
//  Write: on a clk edge with wr_en=1 and count<FIFO_DEPTH, push wr_data. With count==FIFO_DEPTH the word
//   is dropped and overflow is set until reset, even if a pop occurs on the same edge.
//  full/empty are registered from count. A simultaneous push and pop leaves count unchanged.
//  Pointers wrap modulo FIFO_DEPTH; count is $clog2(FIFO_DEPTH)+1 bits.
//  FSM states: IDLE, START, DATA, [PARITY], STOP. Registers: word shifter, byte_idx(2b), bit_idx(3b),
//   baud counter.
//   IDLE:   if !empty, pop the head into the shifter, byte_idx=0, go to START. Otherwise tx=1.
//   START:  tx=0 for CLKS_PER_BIT cycles -> DATA.
//   DATA:   tx=shifter[byte_idx*8+bit_idx], LSB first, CLKS_PER_BIT cycles per bit; after bit 7 -> STOP
//           (or -> PARITY when OUT_PARITY_EN is defined).
//   STOP:   tx=1 for CLKS_PER_BIT cycles. Then, if byte_idx<3, increment byte_idx and go to START.
//           Otherwise go to IDLE.
//  tx is registered (glitch-free). The baud counter reloads on every bit boundary.
//  Latency: a word written at edge N into an empty FIFO with FSM idle -> empty=0 after N, pop at N+1,
//   tx=0 from N+2.
//  Back-to-back words: IDLE lasts one cycle between words. Per-word time = 40*CLKS_PER_BIT+1 cycles
//   (44*CLKS_PER_BIT+1 with parity).
//  A write on the same edge as IDLE's pop of the last word is accepted normally.
//  wr_data is sampled only on an accepted write; later changes do not affect buffered words.
// CONFIGURATION
//  OUT_PARITY_EN defined:
//   - After DATA, a PARITY state drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT
//     cycles, then STOP. Frame is 8E1.
//  OUT_PARITY_EN undefined:
//   - No PARITY state or logic. Frame is 8N1.
// TESTING (CLKS_PER_BIT=4, FIFO_DEPTH=4)
//  1. Reset low mid-sim -> tx=1, busy=0, empty=1, full=0, overflow=0 without waiting for a clk edge.
//  2. Write 32'h44332211 while idle -> tx=0 at write edge+2.
//     Decoded bytes 11,22,33,44 in that order, each start=0/stop=1.
//     busy falls after 161 cycles; empty=1.
//  3. Write 6 words back-to-back while busy=0 -> first popped; FIFO fills (full=1).
//     6th write dropped, overflow=1 and stays 1. Exactly 5 words appear on tx, in order.
//  4. Write on the same edge IDLE pops the last buffered word -> word accepted, count stays 1,
//     no overflow, sent next.
//  5. Pulse rst low during DATA of byte 2 -> tx=1 immediately.
//     Previously queued words are never sent; the next write transmits cleanly from byte 0.
//  6. OUT_PARITY_EN: send 32'h00000103 -> parity bits 0,1,0,0.
//     Each frame is 11 bits; the word takes 177 cycles.

Source files
------------

// File: rtl/cpu_output_uart_if.sv
// Write-side bus of the CPU output UART: core write strobe/data in, FIFO and serializer status out.
interface cpu_output_uart_if #(
    parameter int WORD_SIZE = 32
);
    logic                 wr_en;
    logic [WORD_SIZE-1:0] wr_data;
    logic                 full;
    logic                 empty;
    logic                 busy;
    logic                 overflow;

    modport master (
        output wr_en, wr_data,
        input  full, empty, busy, overflow
    );

    modport slave (
        input  wr_en, wr_data,
        output full, empty, busy, overflow
    );
endinterface

// File: rtl/cpu_output_uart.sv
// Buffers 32-bit CPU output words in a FIFO and sends each as four UART bytes, LSB first.
// Optional OUT_PARITY_EN adds an even-parity bit per byte (8E1 instead of 8N1).
//
// state  | meaning
// IDLE   | line high; pops the FIFO head as soon as one is buffered
// START  | start bit (low) for one bit time
// DATA   | eight data bits of the current byte, LSB first
// PARITY | even parity of the current byte (OUT_PARITY_EN only)
// STOP   | stop bit (high); next byte or back to IDLE after byte 3
module cpu_output_uart #(
    parameter int WORD_SIZE    = 32,
    parameter int FIFO_DEPTH   = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic               clk,
    input  logic               rst,
    cpu_output_uart_if.slave   bus,
    output logic               tx
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] DEPTH     = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LOAD = BW'(CLKS_PER_BIT - 1);

`ifdef OUT_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [WORD_SIZE-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic [CW-1:0]        count_nxt;
    logic                 push;
    logic                 pop;

    state_t               state;
    logic [WORD_SIZE-1:0] shifter;
    logic [1:0]           byte_idx;
    logic [2:0]           bit_idx;
    logic [BW-1:0]        baud_cnt;
    logic                 baud_tc;
    logic [7:0]           cur_byte;

    // A write while full is dropped even if IDLE pops on the same edge.
    assign push     = bus.wr_en && (count != DEPTH);
    assign pop      = (state == IDLE) && !bus.empty;
    assign baud_tc  = (baud_cnt == '0);
    assign cur_byte = shifter[{byte_idx, 3'b000} +: 8];

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + 1'b1;
        else if (!push && pop)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= bus.wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            bus.full     <= 1'b0;
            bus.empty    <= 1'b1;
            bus.overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (bus.wr_en && (count == DEPTH))
                bus.overflow <= 1'b1;
            count     <= count_nxt;
            bus.full  <= (count_nxt == DEPTH);
            bus.empty <= (count_nxt == '0);
        end
    end

    // tx is registered from the current state, so the line trails the state by one clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            shifter  <= '0;
            byte_idx <= '0;
            bit_idx  <= '0;
            baud_cnt <= '0;
            tx       <= 1'b1;
            bus.busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shifter  <= mem[rd_ptr];
                        byte_idx <= '0;
                        bit_idx  <= '0;
                        baud_cnt <= BAUD_LOAD;
                        state    <= START;
                        bus.busy <= 1'b1;
                    end
                end
                START: begin
                    tx <= 1'b0;
                    if (baud_tc) begin
                        baud_cnt <= BAUD_LOAD;
                        bit_idx  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                DATA: begin
                    tx <= cur_byte[bit_idx];
                    if (baud_tc) begin
                        baud_cnt <= BAUD_LOAD;
                        if (bit_idx == 3'd7) begin
`ifdef OUT_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
`ifdef OUT_PARITY_EN
                PARITY: begin
                    tx <= ^cur_byte;
                    if (baud_tc) begin
                        baud_cnt <= BAUD_LOAD;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
`endif
                STOP: begin
                    tx <= 1'b1;
                    if (baud_tc) begin
                        baud_cnt <= BAUD_LOAD;
                        if (byte_idx != 2'd3) begin
                            byte_idx <= byte_idx + 1'b1;
                            state    <= START;
                        end else begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                default: begin
                    tx       <= 1'b1;
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_output_uart.sv
// Directed bench for cpu_output_uart: a line decoder collects bytes from tx and compares them
// against hand-computed vectors, plus sequences for overflow, pop/write collision and reset mid-frame.
module tb_cpu_output_uart;
    localparam int C = 4;
    localparam int D = 4;
`ifdef OUT_PARITY_EN
    localparam int NB       = 11;
    localparam int WORD_CYC = 177;
`else
    localparam int NB       = 10;
    localparam int WORD_CYC = 161;
`endif

    logic clk = 1'b0;
    logic rst;
    logic tx;

    cpu_output_uart_if #(.WORD_SIZE(32)) bus ();

    cpu_output_uart #(
        .WORD_SIZE(32),
        .FIFO_DEPTH(D),
        .CLKS_PER_BIT(C)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .tx(tx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Line decoder: samples each bit at mid-bit time.
    logic [7:0]  rx_q[$];
    logic        rx_par_q[$];
    logic        rx_act;
    int          rx_cnt;
    logic [7:0]  rx_byte;

    initial begin
        int idx;
        rx_act  = 1'b0;
        rx_cnt  = 0;
        rx_byte = '0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                rx_act = 1'b0;
                rx_cnt = 0;
            end else if (!rx_act) begin
                if (tx === 1'b0) begin
                    rx_act = 1'b1;
                    rx_cnt = 0;
                end
            end else begin
                rx_cnt++;
            end
            if (rx_act && (rx_cnt % C) == C / 2) begin
                idx = rx_cnt / C;
                if (idx == 0)
                    check("start_bit", {31'd0, tx}, 32'd0);
                else if (idx <= 8)
                    rx_byte[idx-1] = tx;
                else if (idx == NB - 1) begin
                    check("stop_bit", {31'd0, tx}, 32'd1);
                    rx_q.push_back(rx_byte);
                    rx_act = 1'b0;
                end else
                    rx_par_q.push_back(tx);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [31:0] word;
        logic [7:0]  b0, b1, b2, b3;
    } vec_t;

    vec_t        vecs[5];
    logic [31:0] exp_words[$];

    task automatic push(input logic [31:0] w);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_data = w;
        @(posedge clk);
        #1;
        bus.wr_en   = 1'b0;
        bus.wr_data = 32'hDEADBEEF;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while ((bus.busy || !bus.empty) && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("wait_done_in_budget", {31'd0, n < limit}, 32'd1);
        repeat (2 * C) @(posedge clk);
        #1;
    endtask

    task automatic compare_stream();
        logic [7:0] got;
        check("stream_byte_count", rx_q.size(), 4 * exp_words.size());
        for (int i = 0; i < exp_words.size(); i++) begin
            for (int j = 0; j < 4; j++) begin
                got = (4 * i + j < rx_q.size()) ? rx_q[4*i+j] : 8'hxx;
                check($sformatf("stream_w%0d_b%0d", i, j), {24'd0, got},
                      {24'd0, exp_words[i][8*j +: 8]});
            end
        end
    endtask

    task automatic run_vector(input vec_t v);
        int cyc;
        logic [7:0] got;
        logic [7:0] exp_b[4];
        exp_b[0] = v.b0; exp_b[1] = v.b1; exp_b[2] = v.b2; exp_b[3] = v.b3;
        rx_q.delete();
        push(v.word);
        check("empty_after_write", {31'd0, bus.empty}, 32'd0);
        @(posedge clk); #1;
        check("tx_high_at_pop", {31'd0, tx}, 32'd1);
        check("busy_after_pop", {31'd0, bus.busy}, 32'd1);
        @(posedge clk); #1;
        check("tx_low_at_write_plus2", {31'd0, tx}, 32'd0);
        cyc = 2;
        while (bus.busy && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("word_cycles", cyc, WORD_CYC);
        check("empty_when_done", {31'd0, bus.empty}, 32'd1);
        repeat (C) @(posedge clk); #1;
        check("vec_byte_count", rx_q.size(), 32'd4);
        for (int k = 0; k < 4; k++) begin
            got = (k < rx_q.size()) ? rx_q[k] : 8'hxx;
            check($sformatf("vec_byte%0d", k), {24'd0, got}, {24'd0, exp_b[k]});
        end
    endtask

    initial begin
        logic [31:0] w3[6];
        int n;

        vecs[0] = '{32'h44332211, 8'h11, 8'h22, 8'h33, 8'h44};
        vecs[1] = '{32'hA5C30F81, 8'h81, 8'h0F, 8'hC3, 8'hA5};
        vecs[2] = '{32'h00000000, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[3] = '{32'hFFFFFFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        vecs[4] = '{32'h80000001, 8'h01, 8'h00, 8'h00, 8'h80};

        rst         = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_empty", {31'd0, bus.empty}, 32'd1);
        check("rst_full", {31'd0, bus.full}, 32'd0);
        check("rst_overflow", {31'd0, bus.overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 5; i++)
            run_vector(vecs[i]);

        // Six back-to-back writes into an idle block with a 4-deep FIFO.
        w3[0] = 32'h0A0B0C0D; w3[1] = 32'h11223344; w3[2] = 32'h55667788;
        w3[3] = 32'h99AABBCC; w3[4] = 32'hDDEEFF00; w3[5] = 32'h12345678;
        rx_q.delete();
        exp_words = {w3[0], w3[1], w3[2], w3[3], w3[4]};
        for (int i = 0; i < 6; i++) begin
            push(w3[i]);
            if (i == 4) begin
                check("full_after_5_writes", {31'd0, bus.full}, 32'd1);
                check("no_overflow_yet", {31'd0, bus.overflow}, 32'd0);
            end
        end
        check("overflow_after_drop", {31'd0, bus.overflow}, 32'd1);
        check("full_after_drop", {31'd0, bus.full}, 32'd1);
        wait_done(3000);
        check("overflow_sticky", {31'd0, bus.overflow}, 32'd1);
        compare_stream();

        // Reset during DATA of byte 2 (byte 2 is 0x00, so the line is low there).
        rx_q.delete();
        push(32'h77005544);
        push(32'h11111111);
        push(32'h22222222);
        repeat (93) @(posedge clk);
        #2;
        check("tx_low_before_reset", {31'd0, tx}, 32'd0);
        rst = 1'b0;
        #1;
        check("async_rst_tx", {31'd0, tx}, 32'd1);
        check("async_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("async_rst_empty", {31'd0, bus.empty}, 32'd1);
        check("async_rst_full", {31'd0, bus.full}, 32'd0);
        check("async_rst_overflow", {31'd0, bus.overflow}, 32'd0);
        #10;
        @(negedge clk);
        rst = 1'b1;
        rx_q.delete();
        rx_par_q.delete();
        exp_words = {32'hC0FFEE42};
        push(32'hC0FFEE42);
        wait_done(1000);
        repeat (50) @(posedge clk);
        #1;
        compare_stream();

        // Write on the same edge IDLE pops the last buffered word.
        rx_q.delete();
        exp_words = {32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4};
        push(32'hA1A2A3A4);
        push(32'hB1B2B3B4);
        n = 0;
        while (bus.busy && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_reached", {31'd0, n < 500}, 32'd1);
        check("one_word_buffered", {31'd0, bus.empty}, 32'd0);
        bus.wr_en   = 1'b1;
        bus.wr_data = 32'hC1C2C3C4;
        @(posedge clk); #1;
        bus.wr_en   = 1'b0;
        bus.wr_data = 32'hDEADBEEF;
        check("collide_busy", {31'd0, bus.busy}, 32'd1);
        check("collide_not_empty", {31'd0, bus.empty}, 32'd0);
        check("collide_not_full", {31'd0, bus.full}, 32'd0);
        check("collide_no_overflow", {31'd0, bus.overflow}, 32'd0);
        wait_done(1000);
        compare_stream();

`ifdef OUT_PARITY_EN
        begin
            vec_t pv;
            pv = '{32'h00000103, 8'h03, 8'h01, 8'h00, 8'h00};
            rx_par_q.delete();
            run_vector(pv);
            check("parity_count", rx_par_q.size(), 32'd4);
            check("parity_b0", {31'd0, (rx_par_q.size() > 0) ? rx_par_q[0] : 1'bx}, 32'd0);
            check("parity_b1", {31'd0, (rx_par_q.size() > 1) ? rx_par_q[1] : 1'bx}, 32'd1);
            check("parity_b2", {31'd0, (rx_par_q.size() > 2) ? rx_par_q[2] : 1'bx}, 32'd0);
            check("parity_b3", {31'd0, (rx_par_q.size() > 3) ? rx_par_q[3] : 1'bx}, 32'd0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
